seq_pattern_tx: RTL

Serial pattern transmitter: the driving end of the single-bit sequence interface consumed by the Moore sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, onto `sequence_out`, with programmable idle gap bits between words. It also tracks the transmitted stream against a target pattern (default 1011, overlapping) and emits a reference match pulse and count, cycle-aligned with a Moore detector's output, so benches and on-chip self-test can cross-check detector behaviour.

---
 rtl/seq_pattern_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts accepted words out MSB-first with idle gaps,
// and tracks the emitted stream against a target pattern like a Moore detector.
module seq_pattern_tx #(
  parameter int              WIDTH   = 8,
  parameter int              GAP     = 1,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1011
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             match_pulse,
  output logic [15:0]      match_count
);

  // Handshake: a word transfers at a rising edge where data_valid && data_ready;
  // data_valid may be held while data_ready is low and the word waits unchanged.

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [4:0]    FILL_MAX = 5'(PLEN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    GAP_IDLE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-2:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             seq_q;
  logic [PLEN-1:0]  hist;
  logic [PLEN:0]    hist_ext;
  logic [4:0]       fill;
  logic             is_last;
  logic             accept;
  logic             load;

  assign is_last  = (state == SHIFT) && (bit_cnt == BIT_LAST);
  assign hist_ext = {hist, seq_q};

  always_comb begin
    state_next = state;
    data_ready = 1'b0;
    load       = 1'b0;
    if (reset_n) begin
      data_ready = (state == IDLE) || (is_last && (GAP == 0));
    end
    accept = data_valid && data_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (is_last) begin
          if (GAP > 0) begin
            state_next = GAP_IDLE;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP_IDLE: begin
        if (gap_cnt == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      seq_q       <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
    end else begin
      state <= state_next;
      // shreg holds the bits still to be sent; seq_q is the bit on the wire now.
      if (load) begin
        seq_q   <= data_in[WIDTH-1];
        shreg   <= data_in[WIDTH-2:0];
        bit_cnt <= '0;
      end else if ((state == SHIFT) && !is_last) begin
        seq_q   <= shreg[WIDTH-2];
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        seq_q <= 1'b0;
      end
      if (state == GAP_IDLE) gap_cnt <= gap_cnt + 1'b1;
      else gap_cnt <= '0;
      // History samples every cycle, idle and gap zeros included.
      hist <= hist_ext[PLEN-1:0];
      if (fill != FILL_MAX) fill <= fill + 1'b1;
      if (match_pulse && (match_count != 16'hFFFF)) match_count <= match_count + 1'b1;
    end
  end

  assign match_pulse  = (hist == PATTERN) && (fill == FILL_MAX);
  assign sequence_out = seq_q;
  assign bit_valid    = (state == SHIFT);
  assign last_bit     = is_last;
  assign busy         = (state != IDLE);

endmodule
